// File: rtl/demultiplexer_tdm_1_4.sv
// demultiplexer_tdm_1_4
// Receive-side time-division demultiplexer. A serial stream of samples,
// slot 0 first, is collected into shadow registers. On the slot-3 sample a
// complete frame is published on y0..y3 together with a one-cycle
// frame_valid strobe. A sync marker on slot 0 aligns the block to the frame.
// A missing sync or an early sync raises a one-cycle sync_err pulse.
module demultiplexer_tdm_1_4 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             sync,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic             frame_valid,
   output logic [1:0]       slot,
   output logic             locked,
   output logic             sync_err
);

   localparam logic HUNT = 1'b0;
   localparam logic RUN  = 1'b1;

   logic             state;
   logic [WIDTH-1:0] sh0, sh1, sh2;

   // locked is taken straight from the state flop, so it is still a registered output
   assign locked = (state == RUN);

   // Frame alignment, sample capture and whole-frame publication
   always_ff @(posedge clk) begin
      // NOTE: Sequential state is assigned with <= only. Every register then
      // samples its pre-edge value, whatever order the statements appear in.
      if (rst) begin
         // NOTE: The shadow registers are cleared along with the outputs. A
         // partial frame from before the reset can then never leak into a
         // later published frame.
         state       <= HUNT;
         slot        <= 2'd0;
         sh0         <= '0;
         sh1         <= '0;
         sh2         <= '0;
         y0          <= '0;
         y1          <= '0;
         y2          <= '0;
         y3          <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         // NOTE: Both strobes default low here. Each strobe then lasts exactly
         // one cycle, and no branch below needs an else to clear it.
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
         if (din_valid) begin
            if (state == HUNT) begin
               // Only a sync-marked sample can start a frame. Everything else is dropped.
               if (sync) begin
                  sh0   <= din;
                  slot  <= 2'd1;
                  state <= RUN;
               end
            end else if (sync) begin
               // A sync in slot 0 is expected. A sync in slots 1..3 discards the
               // partial frame and restarts it with this sample.
               sync_err <= (slot != 2'd0);
               sh0      <= din;
               slot     <= 2'd1;
            end else begin
               case (slot)
                  2'd0: begin
                     // The slot-0 sample has no sync marker, so alignment is lost.
                     sync_err <= 1'b1;
                     state    <= HUNT;
                  end
                  2'd1: begin
                     sh1  <= din;
                     slot <= 2'd2;
                  end
                  2'd2: begin
                     sh2  <= din;
                     slot <= 2'd3;
                  end
                  default: begin
                     y0          <= sh0;
                     y1          <= sh1;
                     y2          <= sh2;
                     y3          <= din;
                     frame_valid <= 1'b1;
                     slot        <= 2'd0;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_demultiplexer_tdm_1_4.sv
// tb_demultiplexer_tdm_1_4
// Directed frames from the test plan, then randomized traffic. The DUT is
// compared every cycle against a frame-collecting reference model.
module tb_demultiplexer_tdm_1_4;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] din = '0;
   logic         din_valid = 1'b0;
   logic         sync = 1'b0;
   logic [W-1:0] y0, y1, y2, y3;
   logic         frame_valid, locked, sync_err;
   logic [1:0]   slot;

   demultiplexer_tdm_1_4 #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3), .frame_valid(frame_valid),
      .slot(slot), .locked(locked), .sync_err(sync_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: aligned flag, queue of samples of the frame in progress, last frame
   bit           m_locked;
   bit           m_fv;
   bit           m_err;
   logic [W-1:0] m_y[4];
   logic [W-1:0] part[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input bit s, input logic [W-1:0] d);
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (r) begin
         m_locked = 1'b0;
         part.delete();
         for (int i = 0; i < 4; i++) m_y[i] = '0;
      end else if (v) begin
         if (!m_locked) begin
            if (s) begin
               part.delete();
               part.push_back(d);
               m_locked = 1'b1;
            end
         end else if (s) begin
            m_err = (part.size() != 0);
            part.delete();
            part.push_back(d);
         end else if (part.size() == 0) begin
            m_err    = 1'b1;
            m_locked = 1'b0;
         end else begin
            part.push_back(d);
            if (part.size() == 4) begin
               for (int i = 0; i < 4; i++) m_y[i] = part[i];
               m_fv = 1'b1;
               part.delete();
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [1:0] exp_slot;
      exp_slot = m_locked ? 2'(part.size()) : 2'd0;
      check("y0", 32'(y0), 32'(m_y[0]));
      check("y1", 32'(y1), 32'(m_y[1]));
      check("y2", 32'(y2), 32'(m_y[2]));
      check("y3", 32'(y3), 32'(m_y[3]));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("sync_err", 32'(sync_err), 32'(m_err));
      check("slot", 32'(slot), 32'(exp_slot));
      check("locked", 32'(locked), 32'(m_locked));
   endtask

   // Drive at the falling edge, predict, then compare just after the rising edge
   task automatic apply(input bit r, input bit v, input bit s, input logic [W-1:0] d);
      @(negedge clk);
      rst = r; din_valid = v; sync = s; din = d;
      model_step(r, v, s, d);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic sample(input bit s, input logic [W-1:0] d);
      apply(1'b0, 1'b1, s, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 8'hEE);
   endtask

   // Literal expectations pin both the DUT and the model to hand-computed values
   task automatic pin_frame(input string tag, input logic [31:0] exp);
      check({tag, " dut"}, {y3, y2, y1, y0}, exp);
      check({tag, " model"}, {m_y[3], m_y[2], m_y[1], m_y[0]}, exp);
   endtask

   initial begin
      // Reset state
      apply(1'b1, 1'b0, 1'b0, 8'h00);
      apply(1'b1, 1'b1, 1'b1, 8'h55);
      check("reset y", {y3, y2, y1, y0}, 32'h0);
      check("reset flags", {28'h0, frame_valid, sync_err, locked, 1'b0}, 32'h0);

      // Single frame, then each channel one-hot in turn
      apply(1'b0, 1'b1, 1'b1, 8'h01);
      sample(1'b0, 8'h00);
      sample(1'b0, 8'h00);
      sample(1'b0, 8'h00);
      check("single fv", 32'(frame_valid), 32'h1);
      pin_frame("single", 32'h00000001);
      for (int ch = 0; ch < 4; ch++) begin
         for (int i = 0; i < 4; i++) sample(i == 0, (i == ch) ? 8'h01 : 8'h00);
         pin_frame("onehot", 32'h1 << (8 * ch));
      end

      // Continuous valid, two frames back to back
      sample(1'b1, 8'hA5); check("slot after d0", 32'(slot), 32'h1);
      sample(1'b0, 8'h3C); check("slot after d1", 32'(slot), 32'h2);
      sample(1'b0, 8'h0F); check("slot after d2", 32'(slot), 32'h3);
      sample(1'b0, 8'hF0); check("slot after d3", 32'(slot), 32'h0);
      pin_frame("frame A", 32'hF00F3CA5);
      sample(1'b1, 8'h11);
      check("fv one cycle", 32'(frame_valid), 32'h0);
      sample(1'b0, 8'h22);
      sample(1'b0, 8'h33);
      sample(1'b0, 8'h44);
      check("fv 4 later", 32'(frame_valid), 32'h1);
      pin_frame("frame B", 32'h44332211);

      // Gapped input: three idle cycles between samples
      sample(1'b1, 8'hA5); idle(3);
      check("gap slot hold", 32'(slot), 32'h1);
      sample(1'b0, 8'h3C); idle(3);
      sample(1'b0, 8'h0F); idle(3);
      sample(1'b0, 8'hF0);
      pin_frame("gapped", 32'hF00F3CA5);
      idle(2);

      // Early sync on the third sample
      sample(1'b1, 8'h01);
      sample(1'b0, 8'h02);
      sample(1'b1, 8'h0A);
      check("early err", 32'(sync_err), 32'h1);
      pin_frame("early hold", 32'hF00F3CA5);
      sample(1'b0, 8'h0B);
      sample(1'b0, 8'h0C);
      sample(1'b0, 8'h0D);
      pin_frame("early next", 32'h0D0C0B0A);

      // Missing sync on slot 0, then hunting
      sample(1'b0, 8'h77);
      check("miss err", 32'(sync_err), 32'h1);
      check("miss unlock", 32'(locked), 32'h0);
      sample(1'b0, 8'h78);
      sample(1'b0, 8'h79);
      check("hunt quiet", {30'h0, locked, sync_err}, 32'h0);
      pin_frame("miss hold", 32'h0D0C0B0A);
      sample(1'b1, 8'hC0);
      check("relock", 32'(locked), 32'h1);
      sample(1'b0, 8'hC1);
      sample(1'b0, 8'hC2);
      sample(1'b0, 8'hC3);
      pin_frame("relock frame", 32'hC3C2C1C0);

      // Reset mid-frame, then a full frame
      sample(1'b1, 8'h91);
      sample(1'b0, 8'h92);
      apply(1'b1, 1'b1, 1'b0, 8'h93);
      pin_frame("midreset", 32'h0);
      check("midreset lock", 32'(locked), 32'h0);
      sample(1'b1, 8'hD0);
      sample(1'b0, 8'hD1);
      sample(1'b0, 8'hD2);
      sample(1'b0, 8'hD3);
      pin_frame("post reset", 32'hD3D2D1D0);

      // Randomized traffic, mostly well aligned with occasional faults
      for (int i = 0; i < 3000; i++) begin
         bit r, v, s;
         int p;
         r = ($urandom_range(199) == 0);
         v = ($urandom_range(99) < 70);
         p = $urandom_range(99);
         if (m_locked && part.size() == 0) s = (p < 92);
         else if (!m_locked) s = (p < 30);
         else s = (p < 4);
         apply(r, v, s, 8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
